// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg: shared types and constants for the CoreUART receiver.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE   = 16;
    localparam int         TICK_W       = $clog2(OVERSAMPLE);
    localparam logic [3:0] SAMPLE_POINT = 4'd8;
    localparam logic [3:0] LAST_TICK    = 4'd15;

    function automatic logic majority3(input logic [2:0] w);
        return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_filter: RX synchroniser plus 3-tap majority window.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_rx_filter
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic baud_tick,
    input  logic RX,
    output logic rx_sync,
    output logic vote
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_window;

    // Both stages reset to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync   <= '1;
            r_window <= 3'b111;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
            if (baud_tick) begin
                r_window <= {r_window[1:0], r_sync[SYNC_STAGES-1]};
            end
        end
    end

    assign rx_sync = r_sync[SYNC_STAGES-1];
    assign vote    = majority3(r_window);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_core: 16x oversampled UART receive FSM with parity,      |
// | framing and overflow status. Rev 1.0                             |
// +------------------------------------------------------------------+
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       baud_tick,
    input  logic       RX,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    rx_state_t         r_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_perr_n;

    logic w_rx_sync;
    logic w_vote;
    logic w_sample;
    logic w_last_tick;
    logic w_last_bit;
    logic w_commit;

    uart_rx_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .CLK       (CLK),
        .RESET     (RESET),
        .baud_tick (baud_tick),
        .RX        (RX),
        .rx_sync   (w_rx_sync),
        .vote      (w_vote)
    );

    assign w_sample    = baud_tick && (r_tick_cnt == SAMPLE_POINT);
    assign w_last_tick = baud_tick && (r_tick_cnt == LAST_TICK);
    assign w_last_bit  = (r_bit_idx == (bit8 ? 3'd7 : 3'd6));
    assign w_commit    = w_sample && (r_state == STOP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_perr_n   <= 1'b1;
        end else if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_sync) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                    end
                end
                START: begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                    if (w_sample && w_vote) begin
                        r_state    <= IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_last_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_shift   <= '0;
                        r_perr_n  <= 1'b1;
                    end
                end
                DATA: begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                    if (w_sample) begin
                        r_shift[r_bit_idx] <= w_vote;
                    end
                    // A bit8 change mid-frame just wraps bit_idx until it matches again.
                    if (w_last_tick) begin
                        if (w_last_bit) begin
                            r_state <= parity_en ? PARITY : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                    if (w_sample) begin
                        r_perr_n <= ~((^r_shift) ^ w_vote ^ odd_n_even);
                    end
                    if (w_last_tick) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                    if (w_sample) begin
                        r_state    <= IDLE;
                        r_tick_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    // A commit takes priority over a same-cycle read so the new character is never lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else if (w_commit) begin
            rx_data     <= r_shift;
            parity_err  <= parity_en & ~r_perr_n;
            framing_err <= ~w_vote;
            rx_ready    <= 1'b1;
            overflow    <= read_rx_byte ? 1'b0 : (overflow | rx_ready);
        end else if (read_rx_byte) begin
            rx_ready <= 1'b0;
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx_core: scoreboard bench for the UART receive core.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_rx_core;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic [1:0] div = 2'd0;

    int   checks = 0;
    int   errors = 0;
    int   lat = 0;
    exp_t sb[$];

    uart_rx_core #(
        .SYNC_STAGES (2)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .baud_tick    (baud_tick),
        .RX           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign baud_tick = (div == 2'd3);

    task automatic align_tick();
        @(posedge clk iff baud_tick);
        @(negedge clk);
    endtask

    // A low stop bit is released after 11 ticks so the tail is not mistaken for a new start.
    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_bit, input int spike_bit);
        logic [11:0] fr;
        int          nf;
        logic        v;
        fr = '0;
        nf = 1;
        for (int i = 0; i < nbits; i++) begin
            fr[nf] = data[i];
            nf++;
        end
        if (par_en) begin
            fr[nf] = par_bit;
            nf++;
        end
        fr[nf] = stop_bit;
        nf++;
        align_tick();
        for (int b = 0; b < nf; b++) begin
            for (int t = 0; t < 16; t++) begin
                v = fr[b];
                if (spike_bit >= 0 && b == spike_bit + 1 && t == 7) v = ~v;
                if (b == nf - 1 && t >= 11) v = 1'b1;
                rx = v;
                repeat (TICK_DIV) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic do_read();
        @(negedge clk);
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({rx_data, rx_ready, parity_err, framing_err, overflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got data=%h rdy=%b pe=%b fe=%b ovf=%b, want all 0",
                     rx_data, rx_ready, parity_err, framing_err, overflow);
        end
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_8n1();
        exp_t e;
        bit8 = 1'b1; parity_en = 1'b0;
        sb.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, parity_err, framing_err, overflow} !== {1'b1, e.data, e.perr, e.ferr, 1'b0}) begin
            errors++;
            $display("FAIL 8n1: got rdy=%b data=%h pe=%b fe=%b ovf=%b, want 1 %h %b %b 0",
                     rx_ready, rx_data, parity_err, framing_err, overflow, e.data, e.perr, e.ferr);
        end
        do_read();
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_read: got rdy=%b, want 0", rx_ready);
        end
    endtask

    task automatic test_parity();
        exp_t       e;
        logic [2:0] pbit = 3'b010;
        logic [2:0] odd  = 3'b100;
        bit8 = 1'b1; parity_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            odd_n_even = odd[i];
            sb.push_back('{data: 8'h3C, perr: pbit[i] ^ (^8'h3C) ^ odd[i], ferr: 1'b0});
            send_frame(8'h3C, 8, 1'b1, pbit[i], 1'b1, -1);
            e = sb.pop_front();
            checks++;
            if ({rx_ready, rx_data, parity_err, framing_err} !== {1'b1, e.data, e.perr, e.ferr}) begin
                errors++;
                $display("FAIL parity_%0d: got rdy=%b data=%h pe=%b fe=%b, want 1 %h %b %b",
                         i, rx_ready, rx_data, parity_err, framing_err, e.data, e.perr, e.ferr);
            end
            do_read();
        end
        parity_en = 1'b0; odd_n_even = 1'b0;
    endtask

    task automatic test_7bit_framing();
        exp_t       e;
        logic [7:0] dat[2]  = '{8'h7F, 8'h41};
        logic [1:0] stopb   = 2'b01;
        bit8 = 1'b0; parity_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{data: dat[i] & 8'h7F, perr: 1'b0, ferr: ~stopb[i]});
            send_frame(dat[i], 7, 1'b0, 1'b0, stopb[i], -1);
            e = sb.pop_front();
            checks++;
            if ({rx_ready, rx_data, parity_err, framing_err} !== {1'b1, e.data, e.perr, e.ferr}) begin
                errors++;
                $display("FAIL seven_bit_%0d: got rdy=%b data=%h pe=%b fe=%b, want 1 %h %b %b",
                         i, rx_ready, rx_data, parity_err, framing_err, e.data, e.perr, e.ferr);
            end
            if (i == 0) do_read();
        end
        bit8 = 1'b1;
    endtask

    task automatic test_glitch();
        exp_t e;
        repeat (2 * BIT_CLKS) @(negedge clk);
        do_read();
        align_tick();
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++;
        if ({rx_ready, rx_data} !== {1'b0, 8'h41}) begin
            errors++;
            $display("FAIL false_start: got rdy=%b data=%h, want 0 41", rx_ready, rx_data);
        end
        sb.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 2);
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, framing_err} !== {1'b1, e.data, e.ferr}) begin
            errors++;
            $display("FAIL spike: got rdy=%b data=%h fe=%b, want 1 %h %b",
                     rx_ready, rx_data, framing_err, e.data, e.ferr);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   k;
        do_read();
        sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        align_tick();
        k = 0;
        fork
            send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1);
            begin
                while (rx_ready !== 1'b1 && k < 20 * BIT_CLKS) begin
                    @(negedge clk);
                    k++;
                end
            end
        join
        lat = k;
        e = sb.pop_front();
        checks++;
        if (k >= 20 * BIT_CLKS || rx_data !== e.data) begin
            errors++;
            $display("FAIL ovf_first: got data=%h after %0d clks, want %h within bound", rx_data, k, e.data);
        end
        sb.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1);
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, overflow} !== {1'b1, e.data, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set: got rdy=%b data=%h ovf=%b, want 1 %h 1", rx_ready, rx_data, overflow, e.data);
        end
        do_read();
        checks++;
        if ({rx_ready, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_read: got rdy=%b ovf=%b, want 0 0", rx_ready, overflow);
        end
        sb.push_back('{data: 8'h44, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, -1);
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, overflow} !== {1'b1, e.data, 1'b0}) begin
            errors++;
            $display("FAIL ovf_hold: got rdy=%b data=%h ovf=%b, want 1 %h 0", rx_ready, rx_data, overflow, e.data);
        end
        // The read strobe is placed on the same edge that commits 0x55.
        sb.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0});
        align_tick();
        fork
            send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (lat - 1) @(negedge clk);
                read_rx_byte = 1'b1;
                @(negedge clk);
                read_rx_byte = 1'b0;
            end
        join
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, overflow} !== {1'b1, e.data, 1'b0}) begin
            errors++;
            $display("FAIL collision: got rdy=%b data=%h ovf=%b, want 1 %h 0", rx_ready, rx_data, overflow, e.data);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (5 * BIT_CLKS + BIT_CLKS / 2 + TICK_DIV) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if ({rx_data, rx_ready, parity_err, framing_err, overflow} !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_mid: got data=%h rdy=%b pe=%b fe=%b ovf=%b, want all 0",
                             rx_data, rx_ready, parity_err, framing_err, overflow);
                end
                rst = 1'b0;
            end
        join
        repeat (BIT_CLKS) @(negedge clk);
        checks++;
        if ({rx_data, rx_ready} !== 9'h000) begin
            errors++;
            $display("FAIL reset_abandon: got data=%h rdy=%b, want 00 0", rx_data, rx_ready);
        end
        sb.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
        e = sb.pop_front();
        checks++;
        if ({rx_ready, rx_data, parity_err, framing_err, overflow} !== {1'b1, e.data, e.perr, e.ferr, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: got rdy=%b data=%h pe=%b fe=%b ovf=%b, want 1 %h 0 0 0",
                     rx_ready, rx_data, parity_err, framing_err, overflow, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7bit_framing();
        test_glitch();
        test_overflow();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
